// File: rtl/ped_walk_ctrl.sv
// ---------------------------------------------------------------------------
// ped_walk_ctrl
//
// Pedestrian WALK controller that follows the traffic-light countdown.
// It runs a lockstep mirror of the light phase and the count the light
// controller is expected to present on time_left. The mirror is used to:
//   - grant one WALK per RED phase to a latched pedestrian request,
//   - switch to flashing DON'T-WALK once the remaining RED time reaches
//     the clearance window,
//   - raise a sticky fault whenever time_left departs from the expected
//     sequence. A fault blanks the pedestrian lamps until reset.
//
// Ports
//   clk             in   1  rising-edge clock, shared with the light controller
//   reset           in   1  asynchronous, active-low (0 = in reset)
//   upstream_reset  in   1  light controller's synchronous active-high reset
//   time_left       in   8  light controller countdown, sampled every edge
//   ped_req         in   1  pedestrian button (level), sampled every edge
//   walk            out  1  WALK lamp
//   walk_flash      out  1  flashing DON'T-WALK (clearance window)
//   walk_time_left  out  8  expected count while walk|walk_flash, else 0
//   phase           out  2  mirrored phase: 0=RED, 1=GREEN, 2=YELLOW
//   req_pending     out  1  latched request not yet served
//   fault           out  1  sticky sequence-mismatch flag
//
// All outputs are decoded from registers only, so every sampled input
// reaches the outputs one clock later.
// ---------------------------------------------------------------------------
module ped_walk_ctrl #(
  parameter logic [7:0] RED_RELOAD    = 8'd63,
  parameter logic [7:0] GREEN_RELOAD  = 8'd63,
  parameter logic [7:0] YELLOW_RELOAD = 8'd7,
  parameter logic [7:0] CLEAR_TIME    = 8'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       upstream_reset,
  input  logic [7:0] time_left,
  input  logic       ped_req,
  output logic       walk,
  output logic       walk_flash,
  output logic [7:0] walk_time_left,
  output logic [1:0] phase,
  output logic       req_pending,
  output logic       fault
);

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_BAD    = 2'd3
  } phase_t;

  phase_t     phase_reg,   phase_next;
  logic [7:0] exp_tl_reg,  exp_tl_next;
  logic       pending_reg, pending_next;
  logic       granted_reg, granted_next;
  logic       fault_reg,   fault_next;

  logic       exp_zero;
  logic [7:0] exp_tl_dec;
  logic       lamp_enable;

  assign exp_zero   = (exp_tl_reg == 8'd0);
  assign exp_tl_dec = exp_tl_reg - 8'd1;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg   <= PH_RED;
      exp_tl_reg  <= 8'd0;
      pending_reg <= 1'b0;
      granted_reg <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      exp_tl_reg  <= exp_tl_next;
      pending_reg <= pending_next;
      granted_reg <= granted_next;
      fault_reg   <= fault_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    phase_next   = phase_reg;
    exp_tl_next  = exp_tl_reg;
    pending_next = pending_reg;
    granted_next = granted_reg;
    fault_next   = fault_reg;

    if (upstream_reset) begin
      // The light controller restarts from RED with a zero count, so the
      // mirror does the same. Its time_left is meaningless this edge, hence
      // no compare; requests and the fault flag are left untouched.
      phase_next   = PH_RED;
      exp_tl_next  = 8'd0;
      granted_next = 1'b0;
    end else begin
      if (time_left != exp_tl_reg) begin
        fault_next = 1'b1;
      end

      if (ped_req) begin
        pending_next = 1'b1;
      end

      case (phase_reg)
        PH_RED: begin
          if (exp_zero) begin
            phase_next   = PH_GREEN;
            exp_tl_next  = GREEN_RELOAD;
            granted_next = 1'b0;          // WALK ends when RED ends
          end else begin
            exp_tl_next  = exp_tl_dec;
          end
        end

        PH_GREEN: begin
          if (exp_zero) begin
            phase_next  = PH_YELLOW;
            exp_tl_next = YELLOW_RELOAD;
          end else begin
            exp_tl_next = exp_tl_dec;
          end
        end

        PH_YELLOW: begin
          if (exp_zero) begin
            phase_next  = PH_RED;
            exp_tl_next = RED_RELOAD;
            // Grant on RED entry. A request arriving on this very edge is
            // served too. An existing fault blocks the grant and the request
            // stays latched.
            if ((pending_reg || ped_req) && !fault_reg) begin
              granted_next = 1'b1;
              pending_next = 1'b0;
            end
          end else begin
            exp_tl_next = exp_tl_dec;
          end
        end

        default: begin
          // Encoding 3 cannot be reached by normal sequencing; recover to a
          // known phase and record it as a fault.
          phase_next   = PH_RED;
          exp_tl_next  = 8'd0;
          granted_next = 1'b0;
          fault_next   = 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (registers only)
  // -------------------------------------------------------------------------
  assign lamp_enable    = granted_reg && (phase_reg == PH_RED) && !fault_reg;
  assign walk           = lamp_enable && (exp_tl_reg >  CLEAR_TIME);
  assign walk_flash     = lamp_enable && (exp_tl_reg <= CLEAR_TIME);
  assign walk_time_left = lamp_enable ? exp_tl_reg : 8'd0;
  assign phase          = phase_reg;
  assign req_pending    = pending_reg;
  assign fault          = fault_reg;

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ped_walk_ctrl
//
// Drives ped_walk_ctrl from a behavioural model of the upstream light
// controller. Every edge the expected outputs are pushed to a scoreboard
// queue when the stimulus is driven and popped/compared just after the
// clock edge that produces them.
// ---------------------------------------------------------------------------
module tb_ped_walk_ctrl;

  logic       clk;
  logic       reset;
  logic       upstream_reset;
  logic [7:0] time_left;
  logic       ped_req;
  logic       walk;
  logic       walk_flash;
  logic [7:0] walk_time_left;
  logic [1:0] phase;
  logic       req_pending;
  logic       fault;

  ped_walk_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .upstream_reset (upstream_reset),
    .time_left      (time_left),
    .ped_req        (ped_req),
    .walk           (walk),
    .walk_flash     (walk_flash),
    .walk_time_left (walk_time_left),
    .phase          (phase),
    .req_pending    (req_pending),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int walk;
    int flash;
    int wtl;
    int pend;
    int fault;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: upstream light phase/count plus pedestrian state.
  int m_phase;
  int m_cnt;
  int m_pend;
  int m_grant;
  int m_fault;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_cnt   = 0;
    m_pend  = 0;
    m_grant = 0;
    m_fault = 0;
    sb_q.delete();
  endtask

  // Async reset applied away from the clock edge; outputs must drop at once.
  task automatic reset_cycle(input string tag);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_walk"},  int'(walk),           0);
    check({tag, "_flash"}, int'(walk_flash),     0);
    check({tag, "_wtl"},   int'(walk_time_left), 0);
    check({tag, "_phase"}, int'(phase),          0);
    check({tag, "_pend"},  int'(req_pending),    0);
    check({tag, "_fault"}, int'(fault),          0);
    model_clear();
    ped_req        = 1'b0;
    upstream_reset = 1'b0;
    time_left      = 8'd0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // One transaction: drive inputs, advance the model, push expectation,
  // then compare after the edge.
  task automatic step(input int n, input bit req, input bit ures, input bit glitch);
    exp_t e;
    int   tl;
    int   fault_before;
    int   lit;
    @(negedge clk);
    if (ures)        tl = 8'hA5;      // junk: must not be compared
    else if (glitch) tl = 255;
    else             tl = m_cnt;
    ped_req        = req;
    upstream_reset = ures;
    time_left      = 8'(tl);

    if (ures) begin
      m_phase = 0;
      m_cnt   = 0;
      m_grant = 0;
    end else begin
      fault_before = m_fault;
      if (tl != m_cnt) m_fault = 1;
      if (req) m_pend = 1;
      if (m_cnt == 0) begin
        if (m_phase == 2 && m_pend == 1 && fault_before == 0) begin
          m_grant = 1;
          m_pend  = 0;
        end
        if (m_phase == 0) m_grant = 0;
        m_phase = (m_phase + 1) % 3;
        m_cnt   = (m_phase == 2) ? 7 : 63;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end

    lit     = (m_grant == 1 && m_phase == 0 && m_fault == 0) ? 1 : 0;
    e.phase = m_phase;
    e.walk  = (lit == 1 && m_cnt > 8)  ? 1 : 0;
    e.flash = (lit == 1 && m_cnt <= 8) ? 1 : 0;
    e.wtl   = (lit == 1) ? m_cnt : 0;
    e.pend  = m_pend;
    e.fault = m_fault;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("phase", int'(phase),          e.phase);
    check("walk",  int'(walk),           e.walk);
    check("flash", int'(walk_flash),     e.flash);
    check("wtl",   int'(walk_time_left), e.wtl);
    check("pend",  int'(req_pending),    e.pend);
    check("fault", int'(fault),          e.fault);
    $display("edge %0d tl=%0d req=%0d ur=%0d -> phase=%0d walk=%0d flash=%0d wtl=%0d pend=%0d fault=%0d",
             n, tl, req, ures, phase, walk, walk_flash, walk_time_left, req_pending, fault);
  endtask

  initial begin
    reset          = 1'b0;
    upstream_reset = 1'b0;
    time_left      = 8'd0;
    ped_req        = 1'b0;
    model_clear();

    // Reset state before any clock edge.
    #3;
    check("rst_walk",  int'(walk),           0);
    check("rst_flash", int'(walk_flash),     0);
    check("rst_wtl",   int'(walk_time_left), 0);
    check("rst_phase", int'(phase),          0);
    check("rst_pend",  int'(req_pending),    0);
    check("rst_fault", int'(fault),          0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Run A: normal cycling, request at 10 (served 73), mid-RED request at
    // 100 (served 209), same-edge request at 345, upstream reset at 362
    // during WALK with a junk time_left.
    for (int n = 1; n <= 382; n++) begin
      step(n, (n == 10 || n == 100 || n == 345), (n == 362), 1'b0);
    end

    // Run B: request at 10, time_left glitch at 40 -> sticky fault, no grant
    // at 73, fault survives an upstream reset at 100.
    reset_cycle("rstB");
    for (int n = 1; n <= 150; n++) begin
      step(n, (n == 10), (n == 100), (n == 40));
    end

    // Run C: WALK active with a pending request, then async reset off-edge.
    reset_cycle("rstC");
    for (int n = 1; n <= 80; n++) begin
      step(n, (n == 5 || n == 78), 1'b0, 1'b0);
    end

    // Run D: fault raised while WALK is lit must blank the lamps.
    reset_cycle("rstD");
    for (int n = 1; n <= 140; n++) begin
      step(n, (n == 5), 1'b0, (n == 85));
    end

    reset_cycle("rstE");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
